// File: rtl/popcount_tree_pipe.sv
// Pipelined population-count tree with valid/ready flow control.
// Each level k adds adjacent fields of level k-1 into fields one bit wider.
// Level 0 is the (optionally inverted) input word. Level L holds the final count.
// Every level stalls independently, so an empty level keeps filling even while
// the levels after it are stalled.
module popcount_tree_pipe #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [WIDTH-1:0]            in_data,
    input  logic                        in_mode,
    input  logic [TAG_W-1:0]            in_tag,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [$clog2(WIDTH):0]      out_count,
    output logic [TAG_W-1:0]            out_tag,
    output logic                        out_all,
    output logic                        out_none
);
    localparam int L  = $clog2(WIDTH);
    localparam int CW = L + 1;

    // Bit offset of level k inside the flattened level bus.
    // Level j holds (WIDTH >> j) fields, each j+1 bits wide.
    function automatic int lvl_off(input int k);
        int off;
        off = 0;
        for (int j = 0; j < k; j++) off += (WIDTH >> j) * (j + 1);
        return off;
    endfunction

    localparam int            TOT     = lvl_off(L + 1);
    localparam int            OUT_OFF = lvl_off(L);
    localparam logic [CW-1:0] FULL    = CW'(WIDTH);

    // All levels side by side: level 0 is combinational, levels 1..L are flops.
    logic [TOT-1:0]   lvl;
    logic [L:1]       v_q, v_d, v_prev, adv;
    logic [TAG_W-1:0] tag_q   [1:L];
    logic [TAG_W-1:0] tag_d   [1:L];
    logic [TAG_W-1:0] tag_src [0:L-1];

    assign lvl[0 +: WIDTH] = in_mode ? ~in_data : in_data;
    assign v_prev          = {v_q[L-1:1], in_valid};

    // A level can advance when it is empty, or when the level after it advances.
    always_comb begin
        adv    = '0;
        adv[L] = !v_q[L] || out_ready;
        for (int k = L - 1; k >= 1; k--) adv[k] = !v_q[k] || adv[k+1];
    end

    // Next valid and tag for each level: take from upstream on advance, else hold.
    always_comb begin
        tag_src[0] = in_tag;
        for (int k = 1; k < L; k++) tag_src[k] = tag_q[k];
        v_d = v_q;
        for (int k = 1; k <= L; k++) begin
            tag_d[k] = tag_q[k];
            if (adv[k]) begin
                v_d[k]   = v_prev[k];
                tag_d[k] = tag_src[k-1];
            end
        end
    end

    // Valid and tag registers for all levels.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v_q <= '0;
            for (int k = 1; k <= L; k++) tag_q[k] <= '0;
        end else begin
            v_q <= v_d;
            for (int k = 1; k <= L; k++) tag_q[k] <= tag_d[k];
        end
    end

    for (genvar k = 1; k <= L; k++) begin : g_lvl
        localparam int NF = WIDTH >> k;
        localparam int FW = k + 1;
        localparam int PO = lvl_off(k - 1);
        localparam int CO = lvl_off(k);

        logic [NF*FW-1:0] data_d, data_q;

        // Pairwise zero-extended sums of the previous level, loaded on advance.
        always_comb begin
            data_d = data_q;
            if (adv[k]) begin
                for (int i = 0; i < NF; i++) begin
                    data_d[i*FW +: FW] = {1'b0, lvl[PO + (2*i)*k +: k]}
                                       + {1'b0, lvl[PO + (2*i+1)*k +: k]};
                end
            end
        end

        // Level data register.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) data_q <= '0;
            else       data_q <= data_d;
        end

        assign lvl[CO +: NF*FW] = data_q;
    end

    assign in_ready  = adv[1];
    assign out_valid = v_q[L];
    assign out_count = lvl[OUT_OFF +: CW];
    assign out_tag   = tag_q[L];
    assign out_all   = (out_count == FULL);
    assign out_none  = (out_count == '0);

endmodule
